// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, signedness
// selects and the ALU op codes that launch a divide from the execute stage.
package divider_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_SIGNED   = 1'b1;
   localparam logic DIV_UNSIGNED = 1'b0;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   // Execute-stage helpers: raise start_i and pick signedness from the ALU op.
   function automatic logic div_op_start(input logic [7:0] aluop);
      return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
   endfunction

   function automatic logic div_op_sign(input logic [7:0] aluop);
      return (aluop == EXE_DIV_OP) ? DIV_SIGNED : DIV_UNSIGNED;
   endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface divider_if #(
   parameter int DATA_W = 32
);
   logic                  signed_div;
   logic [DATA_W-1:0]     opdata1;
   logic [DATA_W-1:0]     opdata2;
   logic                  start;
   logic                  annul;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;
   logic                  stall;

   modport master (
      output signed_div, opdata1, opdata2, start, annul,
      input  result, ready, stall
   );

   modport slave (
      input  signed_div, opdata1, opdata2, start, annul,
      output result, ready, stall
   );
endinterface

// File: rtl/divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle, signed or unsigned.
// Result is {remainder, quotient}, registered and held while the requester keeps start high.
module divider
   import divider_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic     clk,
   input  logic     rst,
   divider_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam int RES_W = 2 * DATA_W;

   div_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RES_W:0]      work_q, work_d;
   logic [DATA_W-1:0]   divisor_q, divisor_d;
   logic                neg_quot_q, neg_quot_d;
   logic                neg_rem_q, neg_rem_d;
   logic                ready_q, ready_d;
   logic [RES_W-1:0]    result_q, result_d;

   logic                op1_neg, op2_neg;
   logic [DATA_W-1:0]   op1_abs, op2_abs;

   logic [DATA_W:0]     step_upper;
   logic                step_ge;
   logic [DATA_W-1:0]   step_rem;
   logic [RES_W:0]      step_work;
   logic                last_step;
   logic [DATA_W-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

   // Magnitudes are iterated; the signs are kept aside for the final correction.
   always_comb begin
      op1_neg = (bus.signed_div == DIV_SIGNED) && bus.opdata1[DATA_W-1];
      op2_neg = (bus.signed_div == DIV_SIGNED) && bus.opdata2[DATA_W-1];
      op1_abs = op1_neg ? (DATA_W'(0) - bus.opdata1) : bus.opdata1;
      op2_abs = op2_neg ? (DATA_W'(0) - bus.opdata2) : bus.opdata2;
   end

   // A successful subtract always leaves less than the divisor, so DATA_W bits suffice.
   always_comb begin
      step_upper = work_q[RES_W:DATA_W];
      step_ge    = step_upper >= {1'b0, divisor_q};
      step_rem   = step_upper[DATA_W-1:0] - divisor_q;
      step_work  = step_ge ? {step_rem, work_q[DATA_W-1:0], 1'b1}
                           : {work_q[RES_W-1:0], 1'b0};
      quot_raw   = step_work[DATA_W-1:0];
      rem_raw    = step_work[RES_W:DATA_W+1];
      quot_fix   = neg_quot_q ? (DATA_W'(0) - quot_raw) : quot_raw;
      rem_fix    = neg_rem_q  ? (DATA_W'(0) - rem_raw)  : rem_raw;
      last_step  = (cnt_q == CNT_W'(DATA_W - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DIV_FREE;
         cnt_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         ready_q    <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         ready_q    <= ready_d;
         result_q   <= result_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;

      case (state_q)
         DIV_FREE: begin
            if (bus.start && !bus.annul) begin
               divisor_d  = op2_abs;
               neg_quot_d = op1_neg ^ op2_neg;
               neg_rem_d  = op1_neg;
               cnt_d      = '0;
               work_d     = {{DATA_W{1'b0}}, op1_abs, 1'b0};
               state_d    = (bus.opdata2 == '0) ? DIV_BYZERO : DIV_ON;
            end
         end
         DIV_BYZERO: begin
            state_d = DIV_END;
         end
         DIV_ON: begin
            work_d = step_work;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = DIV_END;
            end
         end
         DIV_END: begin
            if (!bus.start) begin
               state_d = DIV_FREE;
            end
         end
         default: state_d = DIV_FREE;
      endcase

      if (bus.annul) begin
         state_d = DIV_FREE;
         cnt_d   = '0;
         work_d  = '0;
      end
   end

   // Outputs are registered; they follow the state being entered.
   always_comb begin
      ready_d  = 1'b0;
      result_d = '0;
      if (state_d == DIV_END) begin
         ready_d = 1'b1;
         case (state_q)
            DIV_ON:  result_d = {rem_fix, quot_fix};
            DIV_END: result_d = result_q;
            default: result_d = '0;
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.result = result_q;
   assign bus.stall  = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: latency, signed/unsigned results, divide by zero,
// annul, reset and back-to-back handshakes.
module tb_divider;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   divider_if #(.DATA_W(32)) dif ();

   divider #(.DATA_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   // Issue one divide at the next edge, hold start until ready, then drop start.
   task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res,
                         output int stall_cnt, output logic stall_at_ready);
      @(posedge clk); #1;
      dif.signed_div = sd;
      dif.opdata1    = a;
      dif.opdata2    = b;
      dif.start      = 1'b1;
      lat            = -1;
      stall_cnt      = 0;
      res            = '0;
      stall_at_ready = 1'bx;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (dif.ready === 1'b1) begin
            lat            = c;
            res            = dif.result;
            stall_at_ready = dif.stall;
            break;
         end
         if (dif.stall === 1'b1) stall_cnt++;
      end
      $display("op sd=%0d %h / %h -> %h latency %0d", sd, a, b, res, lat);
      @(posedge clk); #1;
      dif.start = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      dif.start      = 1'b0;
      dif.annul      = 1'b0;
      dif.signed_div = 1'b0;
      dif.opdata1    = '0;
      dif.opdata2    = '0;
      repeat (2) @(posedge clk);
      #1 dif.start = 1'b1;
      #1;
      checks++;
      if (dif.stall !== 1'b1) begin
         errors++; $display("FAIL reset_stall_start: got %b expected 1", dif.stall);
      end
      dif.start = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (dif.ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b expected 0", dif.ready);
      end
      checks++;
      if (dif.result !== 64'h0) begin
         errors++; $display("FAIL reset_result: got %h expected 0", dif.result);
      end
      checks++;
      if (dif.stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b expected 0", dif.stall);
      end
   endtask

   task automatic test_unsigned();
      int lat, sc; logic [63:0] res; logic sr;
      run_op(1'b0, 32'd100, 32'd7, lat, res, sc, sr);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL u100_7_latency: got %0d expected 33", lat); end
      checks++;
      if (res !== {32'h2, 32'hE}) begin errors++; $display("FAIL u100_7_result: got %h expected %h", res, {32'h2, 32'hE}); end
      checks++;
      if (sc !== 33) begin errors++; $display("FAIL u100_7_stall_cycles: got %0d expected 33", sc); end
      checks++;
      if (sr !== 1'b0) begin errors++; $display("FAIL u100_7_stall_at_ready: got %b expected 0", sr); end
      @(negedge clk);
      checks++;
      if (dif.ready !== 1'b1) begin errors++; $display("FAIL end_hold_ready: got %b expected 1", dif.ready); end
      @(negedge clk);
      checks++;
      if (dif.ready !== 1'b0 || dif.result !== 64'h0) begin
         errors++; $display("FAIL end_to_free: got ready %b result %h expected 0 and 0", dif.ready, dif.result);
      end
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sc, sr);
      checks++;
      if (res !== {32'h8000_0000, 32'h0}) begin
         errors++; $display("FAIL u_big_result: got %h expected %h", res, {32'h8000_0000, 32'h0});
      end
   endtask

   task automatic test_signed();
      logic [31:0] a_tab [4];
      logic [31:0] b_tab [4];
      logic [63:0] e_tab [4];
      int lat, sc; logic [63:0] res; logic sr;
      a_tab[0] = 32'hFFFF_FFF9; b_tab[0] = 32'd2;          e_tab[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      a_tab[1] = 32'h8000_0000; b_tab[1] = 32'hFFFF_FFFF;  e_tab[1] = {32'h0000_0000, 32'h8000_0000};
      a_tab[2] = 32'd7;         b_tab[2] = 32'hFFFF_FFFE;  e_tab[2] = {32'h0000_0001, 32'hFFFF_FFFD};
      a_tab[3] = 32'hFFFF_FF9C; b_tab[3] = 32'd7;          e_tab[3] = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
      for (int i = 0; i < 4; i++) begin
         run_op(1'b1, a_tab[i], b_tab[i], lat, res, sc, sr);
         checks++;
         if (lat !== 33) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat); end
         checks++;
         if (res !== e_tab[i]) begin errors++; $display("FAIL signed_result[%0d]: got %h expected %h", i, res, e_tab[i]); end
      end
   endtask

   task automatic test_byzero();
      int lat, sc; logic [63:0] res; logic sr;
      for (int i = 0; i < 2; i++) begin
         run_op(i[0], (i == 0) ? 32'd5 : 32'hFFFF_FFFB, 32'd0, lat, res, sc, sr);
         checks++;
         if (lat !== 2) begin errors++; $display("FAIL byzero_latency[%0d]: got %0d expected 2", i, lat); end
         checks++;
         if (res !== 64'h0) begin errors++; $display("FAIL byzero_result[%0d]: got %h expected 0", i, res); end
         checks++;
         if (sc !== 2 || sr !== 1'b0) begin
            errors++; $display("FAIL byzero_stall[%0d]: got %0d high, %b at ready, expected 2 high, 0 at ready", i, sc, sr);
         end
      end
   endtask

   task automatic test_annul();
      int lat, sc, rdy_cnt; logic [63:0] res; logic sr;
      @(posedge clk); #1;
      dif.signed_div = 1'b0; dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3; dif.start = 1'b1;
      rdy_cnt = 0;
      repeat (11) begin
         @(negedge clk); if (dif.ready === 1'b1) rdy_cnt++;
         @(posedge clk); #1;
      end
      dif.annul = 1'b1;
      #1;
      checks++;
      if (dif.stall !== 1'b0) begin errors++; $display("FAIL annul_stall: got %b expected 0", dif.stall); end
      @(posedge clk); #1;
      dif.annul = 1'b0;
      dif.start = 1'b0;
      @(negedge clk); if (dif.ready === 1'b1) rdy_cnt++;
      checks++;
      if (dif.result !== 64'h0) begin errors++; $display("FAIL annul_result: got %h expected 0", dif.result); end
      @(negedge clk); if (dif.ready === 1'b1) rdy_cnt++;
      checks++;
      if (rdy_cnt !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", rdy_cnt); end
      run_op(1'b0, 32'd1000, 32'd3, lat, res, sc, sr);
      checks++;
      if (lat !== 33 || res !== {32'd1, 32'd333}) begin
         errors++; $display("FAIL annul_restart: got latency %0d result %h expected 33 and %h", lat, res, {32'd1, 32'd333});
      end
   endtask

   task automatic test_annul_priority();
      int rdy_cnt;
      @(posedge clk); #1;
      dif.signed_div = 1'b0; dif.opdata1 = 32'd9; dif.opdata2 = 32'd3;
      dif.start = 1'b1; dif.annul = 1'b1;
      @(negedge clk);
      checks++;
      if (dif.stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b expected 0", dif.stall); end
      @(posedge clk); #1;
      dif.start = 1'b0; dif.annul = 1'b0;
      rdy_cnt = 0;
      repeat (40) begin @(negedge clk); if (dif.ready === 1'b1) rdy_cnt++; end
      $display("annul with start: %0d ready cycles", rdy_cnt);
      checks++;
      if (rdy_cnt !== 0) begin errors++; $display("FAIL prio_no_ready: got %0d ready cycles expected 0", rdy_cnt); end
   endtask

   task automatic test_start_toggle();
      int lat; logic [63:0] res;
      @(posedge clk); #1;
      dif.signed_div = 1'b0; dif.opdata1 = 32'd100; dif.opdata2 = 32'd7; dif.start = 1'b1;
      lat = -1; res = '0;
      for (int c = 0; c < 100; c++) begin
         if (c == 5) begin
            dif.start = 1'b0; dif.opdata1 = 32'd999; dif.opdata2 = 32'd0; dif.signed_div = 1'b1;
         end
         if (c == 8) dif.start = 1'b1;
         @(negedge clk);
         if (dif.ready === 1'b1) begin lat = c; res = dif.result; break; end
         @(posedge clk); #1;
      end
      $display("toggle op 100/7 -> %h latency %0d", res, lat);
      checks++;
      if (lat !== 33 || res !== {32'h2, 32'hE}) begin
         errors++; $display("FAIL toggle_ignored: got latency %0d result %h expected 33 and %h", lat, res, {32'h2, 32'hE});
      end
      @(posedge clk); #1;
      dif.start = 1'b0; dif.signed_div = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int lat, sc; logic [63:0] res; logic sr;
      run_op(1'b0, 32'hFFFF_FFFF, 32'h10, lat, res, sc, sr);
      checks++;
      if (lat !== 33 || res !== {32'h0000_000F, 32'h0FFF_FFFF}) begin
         errors++; $display("FAIL b2b_first: got latency %0d result %h expected 33 and %h", lat, res, {32'h0000_000F, 32'h0FFF_FFFF});
      end
      @(negedge clk);
      checks++;
      if (dif.ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_hold: got %b expected 1", dif.ready); end
      run_op(1'b0, 32'd5, 32'd5, lat, res, sc, sr);
      checks++;
      if (lat !== 33 || res !== {32'd0, 32'd1}) begin
         errors++; $display("FAIL b2b_second: got latency %0d result %h expected 33 and %h", lat, res, {32'd0, 32'd1});
      end
   endtask

   task automatic test_reset_mid();
      int rdy_cnt, lat;
      @(posedge clk); #1;
      dif.signed_div = 1'b0; dif.opdata1 = 32'd100; dif.opdata2 = 32'd7; dif.start = 1'b1;
      repeat (15) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (dif.ready !== 1'b0 || dif.result !== 64'h0) begin
         errors++; $display("FAIL rst_on_outputs: got ready %b result %h expected 0 and 0", dif.ready, dif.result);
      end
      dif.start = 1'b0;
      #2 rst = 1'b0;
      rdy_cnt = 0;
      repeat (40) begin @(negedge clk); if (dif.ready === 1'b1) rdy_cnt++; end
      checks++;
      if (rdy_cnt !== 0) begin errors++; $display("FAIL rst_on_no_ready: got %0d ready cycles expected 0", rdy_cnt); end
      // Second pass: reset while a result is being held in END.
      @(posedge clk); #1;
      dif.start = 1'b1;
      lat = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (dif.ready === 1'b1) begin lat = c; break; end
      end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL rst_end_latency: got %0d expected 33", lat); end
      @(negedge clk);
      checks++;
      if (dif.ready !== 1'b1 || dif.result !== {32'h2, 32'hE}) begin
         errors++; $display("FAIL end_held: got ready %b result %h expected 1 and %h", dif.ready, dif.result, {32'h2, 32'hE});
      end
      #2 rst = 1'b1;
      #1;
      $display("async reset in END: ready %b result %h", dif.ready, dif.result);
      checks++;
      if (dif.ready !== 1'b0 || dif.result !== 64'h0) begin
         errors++; $display("FAIL rst_end_outputs: got ready %b result %h expected 0 and 0", dif.ready, dif.result);
      end
      dif.start = 1'b0;
      #4 rst = 1'b0;
      rdy_cnt = 0;
      repeat (5) begin @(negedge clk); if (dif.ready === 1'b1) rdy_cnt++; end
      checks++;
      if (rdy_cnt !== 0) begin errors++; $display("FAIL rst_end_no_ready: got %0d ready cycles expected 0", rdy_cnt); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_byzero();
      test_annul();
      test_annul_priority();
      test_start_toggle();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DATA_W, default 32: operand width; the result is 2*DATA_W wide.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  DATA_W  dividend; sampled with start_i.
REQ-006 opdata2_i  input  DATA_W  divisor; sampled with start_i.
REQ-007 start_i  input  1  request from the E stage; held high until ready_o is seen.
REQ-008 annul_i  input  1  abort the in-flight divide; driven by the exception flush.
REQ-009 result_o  output  2*DATA_W  {remainder(hi), quotient(lo)}.
REQ-010 ready_o  output  1  result_o is valid this cycle.
REQ-011 stall_o  output  1  div_stall to the hazard unit.

Function
REQ-012 State machine SHALL have four states:
- FREE: idle.
- BYZERO: divisor is zero.
- ON: iterating.
- END: result presented.
REQ-013 FREE: start_i=1 and annul_i=0 SHALL latch operands and signedness; go to BYZERO if opdata2_i==0, else go to ON with the step counter cleared.
REQ-014 Signed mode SHALL iterate on the absolute values of both operands.
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle:
- Working register is 2*DATA_W+1 bits.
- Subtract the divisor from the upper DATA_W+1 bits.
- Shift in 1 if the difference is non-negative, else shift in 0 and keep the old value.
REQ-016 After exactly DATA_W steps, ON SHALL go to END.
REQ-017 Latency: ready_o SHALL rise DATA_W+1 cycles after the first cycle start_i is high (33 for DATA_W=32).
REQ-018 Signed correction applied on entry to END:
- Quotient is negated when the operand signs differ.
- Remainder is negated when the dividend is negative.
REQ-019 INT_MIN / -1 (signed) SHALL yield quotient 0x80000000 and remainder 0, without error.
REQ-020 BYZERO SHALL go to END after one cycle with result_o = 0; ready_o SHALL rise 2 cycles after start.
REQ-021 END: ready_o=1 and result_o is held stable while start_i=1.
REQ-022 END with start_i=0: go to FREE, ready_o=0, result_o=0.
REQ-023 stall_o SHALL equal start_i & ~ready_o & ~annul_i, combinationally.
REQ-024 annul_i=1 in any state SHALL force FREE at the next edge; ready_o=0 and result_o=0 that cycle.
REQ-025 annul_i takes priority over start_i on the same edge.
REQ-026 start_i toggles while in ON SHALL be ignored; operands are sampled only in FREE.
REQ-027 Back-to-back divides: FREE is re-entered for at least one cycle between results; a new start is accepted the cycle after FREE is re-entered.

Reset
REQ-028 rst=1 SHALL force, asynchronously:
- state = FREE, counter = 0, working register = 0;
- ready_o = 0, result_o = 0.
REQ-029 Reset during ON or END SHALL discard the operation; after rst deasserts, no ready_o appears unless start_i is asserted anew.

Structure
REQ-030 The shared defines header SHALL hold:
- state encodings (FREE, BYZERO, ON, END);
- signed/unsigned select constants;
- the DIV/DIVU alu-op codes used to generate start_i.
REQ-031 The block SHALL be a single module with no sub-modules; the per-step subtract is inline combinational logic.

Verification
REQ-032 Unsigned 100/7, start held -> ready_o at cycle 33, result_o = {0x00000002, 0x0000000E}, stall_o high for cycles 0-32.
REQ-033 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-034 Divisor 0 (either mode) -> BYZERO, ready_o at cycle 2, result_o = 0, stall_o low from cycle 2.
REQ-035 annul_i pulsed at cycle 10 of ON -> state FREE next cycle, ready_o never rises, stall_o low; a new start 2 cycles later gives a correct result at +33.
REQ-036 rst asserted mid-ON asynchronously -> outputs zero immediately; with start_i low after release, ready_o stays 0.
REQ-037 Back-to-back 0xFFFFFFFF/0x10 unsigned then 5/5 -> {0x0000000F, 0x0FFFFFFF}, then {0, 1}, with one FREE cycle between them.
